// File: rtl/control_multi.sv
// Multicycle RV32I/RV32M control unit: Moore FSM sharing one ALU and one memory port.
// Latency: 3 cycles (branch/jal/jalr) to 5 (load), 3+MULDIV_LAT for M-ops, plus memory waits.
// Backpressure: FETCH, MEM_LD and MEM_ST hold until iMemReady; ERROR is sticky until reset.
module control_multi #(
    parameter int RV32M      = 1,
    parameter int MULDIV_LAT = 8      // legal range 1..63
) (
    input  logic        iCLK,
    input  logic        iRSTn,
    input  logic [31:0] iInstr,
    input  logic        iMemReady,
    output logic        oEscrevePC,
    output logic        oEscrevePCCond,
    output logic        oEscrevePCBack,
    output logic        oEscreveIR,
    output logic        oIouD,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oRegWrite,
    output logic [1:0]  oOrigAULA,
    output logic [1:0]  oOrigBULA,
    output logic [1:0]  oMem2Reg,
    output logic        oOrigPC,
    output logic [4:0]  oALUControl,
    output logic [3:0]  oState,
    output logic        oIllegal
);

    // Opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operation codes shared with the datapath ALU
    localparam logic [4:0] OPAND    = 5'd0;
    localparam logic [4:0] OPOR     = 5'd1;
    localparam logic [4:0] OPXOR    = 5'd2;
    localparam logic [4:0] OPADD    = 5'd3;
    localparam logic [4:0] OPSUB    = 5'd4;
    localparam logic [4:0] OPSLT    = 5'd5;
    localparam logic [4:0] OPSLTU   = 5'd6;
    localparam logic [4:0] OPSLL    = 5'd7;
    localparam logic [4:0] OPSRL    = 5'd8;
    localparam logic [4:0] OPSRA    = 5'd9;
    localparam logic [4:0] OPLUI    = 5'd10;
    localparam logic [4:0] OPMUL    = 5'd11;
    localparam logic [4:0] OPMULH   = 5'd12;
    localparam logic [4:0] OPMULHSU = 5'd13;
    localparam logic [4:0] OPMULHU  = 5'd14;
    localparam logic [4:0] OPDIV    = 5'd15;
    localparam logic [4:0] OPDIVU   = 5'd16;
    localparam logic [4:0] OPREM    = 5'd17;
    localparam logic [4:0] OPREMU   = 5'd18;
    localparam logic [4:0] OPNULL   = 5'd31;

    localparam logic [5:0] MD_LOAD = 6'(MULDIV_LAT - 1);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_ADDR    = 4'd4,
        S_MEM_LD  = 4'd5,
        S_MEM_ST  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_JALR    = 4'd11,
        S_MD_WAIT = 4'd12,
        S_ERROR   = 4'd13
    } state_t;

    state_t     state, next_state, decode_next;
    logic [5:0] cnt, cnt_next;
    logic [4:0] arith_op, md_op;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = iInstr[6:0];
    assign funct3 = iInstr[14:12];
    assign funct7 = iInstr[31:25];
    // Register and immediate fields belong to the datapath, not to sequencing.
    assign unused_instr_bits = ^{iInstr[24:15], iInstr[11:7]};

    // Decode legality and the state that follows DECODE.
    always_comb begin
        decode_next = S_ERROR;
        case (opcode)
            OPC_RTYPE: begin
                if (funct7 == F7_ZERO)
                    decode_next = S_EXEC_R;
                else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
                    decode_next = S_EXEC_R;
                else if (funct7 == F7_MULDIV && RV32M != 0)
                    decode_next = S_MD_WAIT;
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001)
                    decode_next = (funct7 == F7_ZERO) ? S_EXEC_I : S_ERROR;
                else if (funct3 == 3'b101)
                    decode_next = (funct7 == F7_ZERO || funct7 == F7_ALT) ? S_EXEC_I : S_ERROR;
                else
                    decode_next = S_EXEC_I;
            end
            OPC_LUI, OPC_AUIPC: decode_next = S_EXEC_I;
            OPC_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
                    decode_next = S_ADDR;
            end
            OPC_STORE:  if (funct3 <= 3'b010) decode_next = S_ADDR;
            OPC_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) decode_next = S_BRANCH;
            OPC_JAL:    decode_next = S_JAL;
            OPC_JALR:   if (funct3 == 3'b000) decode_next = S_JALR;
            default:    decode_next = S_ERROR;
        endcase
    end

    // ALU codes for base arithmetic (R and I forms) and for the M extension.
    always_comb begin
        arith_op = OPNULL;
        md_op    = OPNULL;
        case (funct3)
            3'b000: arith_op = (opcode == OPC_RTYPE && funct7[5]) ? OPSUB : OPADD;
            3'b001: arith_op = OPSLL;
            3'b010: arith_op = OPSLT;
            3'b011: arith_op = OPSLTU;
            3'b100: arith_op = OPXOR;
            3'b101: arith_op = funct7[5] ? OPSRA : OPSRL;
            3'b110: arith_op = OPOR;
            3'b111: arith_op = OPAND;
        endcase
        case (funct3)
            3'b000: md_op = OPMUL;
            3'b001: md_op = OPMULH;
            3'b010: md_op = OPMULHSU;
            3'b011: md_op = OPMULHU;
            3'b100: md_op = OPDIV;
            3'b101: md_op = OPDIVU;
            3'b110: md_op = OPREM;
            3'b111: md_op = OPREMU;
        endcase
    end

    // State register and MUL/DIV wait counter.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next state and control outputs; everything forced low while in reset.
    always_comb begin
        next_state     = state;
        cnt_next       = cnt;
        oEscrevePC     = 1'b0;
        oEscrevePCCond = 1'b0;
        oEscrevePCBack = 1'b0;
        oEscreveIR     = 1'b0;
        oIouD          = 1'b0;
        oMemRead       = 1'b0;
        oMemWrite      = 1'b0;
        oRegWrite      = 1'b0;
        oOrigAULA      = 2'b00;
        oOrigBULA      = 2'b00;
        oMem2Reg       = 2'b00;
        oOrigPC        = 1'b0;
        oALUControl    = OPNULL;
        oIllegal       = 1'b0;
        oState         = state;
        case (state)
            S_FETCH: begin
                oMemRead    = 1'b1;
                oOrigAULA   = 2'b01;
                oOrigBULA   = 2'b01;
                oALUControl = OPADD;
                if (iMemReady) begin
                    oEscreveIR     = 1'b1;
                    oEscrevePC     = 1'b1;
                    oEscrevePCBack = 1'b1;
                    next_state     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch/jump target: PCBack + imm into ALUOut.
                oOrigAULA   = 2'b10;
                oOrigBULA   = 2'b10;
                oALUControl = OPADD;
                next_state  = decode_next;
                if (decode_next == S_MD_WAIT)
                    cnt_next = MD_LOAD;
            end
            S_EXEC_R: begin
                oALUControl = arith_op;
                next_state  = S_WB_ALU;
            end
            S_EXEC_I: begin
                oOrigBULA  = 2'b10;
                next_state = S_WB_ALU;
                if (opcode == OPC_LUI)
                    oALUControl = OPLUI;
                else if (opcode == OPC_AUIPC) begin
                    oOrigAULA   = 2'b10;
                    oALUControl = OPADD;
                end else
                    oALUControl = arith_op;
            end
            S_MD_WAIT: begin
                oALUControl = md_op;
                if (cnt == 6'd0)
                    next_state = S_WB_ALU;
                else
                    cnt_next = cnt - 6'd1;
            end
            S_WB_ALU: begin
                oRegWrite  = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDR: begin
                oOrigBULA   = 2'b10;
                oALUControl = OPADD;
                next_state  = (opcode == OPC_LOAD) ? S_MEM_LD : S_MEM_ST;
            end
            S_MEM_LD: begin
                oMemRead = 1'b1;
                oIouD    = 1'b1;
                if (iMemReady)
                    next_state = S_WB_MEM;
            end
            S_WB_MEM: begin
                oRegWrite  = 1'b1;
                oMem2Reg   = 2'b10;
                next_state = S_FETCH;
            end
            S_MEM_ST: begin
                oMemWrite = 1'b1;
                oIouD     = 1'b1;
                if (iMemReady)
                    next_state = S_FETCH;
            end
            S_BRANCH: begin
                oALUControl    = OPSUB;
                oEscrevePCCond = 1'b1;
                oOrigPC        = 1'b1;
                next_state     = S_FETCH;
            end
            S_JAL: begin
                oRegWrite  = 1'b1;
                oMem2Reg   = 2'b01;
                oEscrevePC = 1'b1;
                oOrigPC    = 1'b1;
                next_state = S_FETCH;
            end
            S_JALR: begin
                oOrigBULA   = 2'b10;
                oALUControl = OPADD;
                oEscrevePC  = 1'b1;
                oRegWrite   = 1'b1;
                oMem2Reg    = 2'b01;
                next_state  = S_FETCH;
            end
            S_ERROR: begin
                oIllegal = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
        if (!iRSTn) begin
            oEscrevePC     = 1'b0;
            oEscrevePCCond = 1'b0;
            oEscrevePCBack = 1'b0;
            oEscreveIR     = 1'b0;
            oIouD          = 1'b0;
            oMemRead       = 1'b0;
            oMemWrite      = 1'b0;
            oRegWrite      = 1'b0;
            oOrigAULA      = 2'b00;
            oOrigBULA      = 2'b00;
            oMem2Reg       = 2'b00;
            oOrigPC        = 1'b0;
            oALUControl    = 5'd0;
            oIllegal       = 1'b0;
            oState         = 4'd0;
        end
    end

endmodule

// File: tb/tb_control_multi.sv
// Bench for control_multi: directed program plus random instruction stream vs a trace model.
// Latency: model builds the expected per-cycle state trace of each instruction up front.
// Backpressure: memory waits are scripted per instruction; iMemReady is random elsewhere.
module tb_control_multi;

    localparam int LAT = 8;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC_R = 2, ST_EXEC_I = 3, ST_ADDR = 4;
    localparam int ST_MEM_LD = 5, ST_MEM_ST = 6, ST_WB_ALU = 7, ST_WB_MEM = 8, ST_BRANCH = 9;
    localparam int ST_JAL = 10, ST_JALR = 11, ST_MD_WAIT = 12, ST_ERROR = 13;

    localparam int K_ILL = 0, K_R = 1, K_MD = 2, K_I = 3, K_LD = 4, K_ST = 5;
    localparam int K_BR = 6, K_JAL = 7, K_JALR = 8;

    localparam logic [4:0] OPADD = 5'd3, OPSUB = 5'd4, OPSRL = 5'd8, OPSRA = 5'd9;
    localparam logic [4:0] OPLUI = 5'd10, OPNULL = 5'd31;

    // funct3-indexed mnemonic tables: add sll slt sltu xor srl or and / mul..remu
    localparam logic [4:0] BASE_TAB [8] = '{5'd3, 5'd7, 5'd5, 5'd6, 5'd2, 5'd8, 5'd1, 5'd0};
    localparam logic [4:0] MD_TAB   [8] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18};
    localparam logic [6:0] OPC_TAB  [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

    logic        iCLK = 1'b0;
    logic        iRSTn = 1'b0;
    logic [31:0] iInstr = '0;
    logic        iMemReady = 1'b0;
    logic        oEscrevePC, oEscrevePCCond, oEscrevePCBack, oEscreveIR, oIouD;
    logic        oMemRead, oMemWrite, oRegWrite, oOrigPC, oIllegal;
    logic [1:0]  oOrigAULA, oOrigBULA, oMem2Reg;
    logic [4:0]  oALUControl;
    logic [3:0]  oState;

    logic [31:0] instr_b = '0;
    logic        rdy_b = 1'b0;
    logic        pc_b, pcc_b, pcb_b, ir_b, iou_b, mr_b, mw_b, rw_b, opc_b, ill_b;
    logic [1:0]  a_b, b_b, m2r_b;
    logic [4:0]  alu_b;
    logic [3:0]  state_b;

    logic [20:0] act;
    int          n_checks = 0;
    int          n_errors = 0;
    int          q_st[$];
    bit          q_rdy[$];

    control_multi #(.RV32M(1), .MULDIV_LAT(LAT)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iInstr(iInstr), .iMemReady(iMemReady),
        .oEscrevePC(oEscrevePC), .oEscrevePCCond(oEscrevePCCond), .oEscrevePCBack(oEscrevePCBack),
        .oEscreveIR(oEscreveIR), .oIouD(oIouD), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
        .oRegWrite(oRegWrite), .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA), .oMem2Reg(oMem2Reg),
        .oOrigPC(oOrigPC), .oALUControl(oALUControl), .oState(oState), .oIllegal(oIllegal)
    );

    control_multi #(.RV32M(0), .MULDIV_LAT(1)) dut_nom (
        .iCLK(iCLK), .iRSTn(iRSTn), .iInstr(instr_b), .iMemReady(rdy_b),
        .oEscrevePC(pc_b), .oEscrevePCCond(pcc_b), .oEscrevePCBack(pcb_b),
        .oEscreveIR(ir_b), .oIouD(iou_b), .oMemRead(mr_b), .oMemWrite(mw_b),
        .oRegWrite(rw_b), .oOrigAULA(a_b), .oOrigBULA(b_b), .oMem2Reg(m2r_b),
        .oOrigPC(opc_b), .oALUControl(alu_b), .oState(state_b), .oIllegal(ill_b)
    );

    always #5 iCLK = ~iCLK;

    assign act = {oEscrevePC, oEscrevePCCond, oEscrevePCBack, oEscreveIR, oIouD, oMemRead,
                  oMemWrite, oRegWrite, oOrigAULA, oOrigBULA, oMem2Reg, oOrigPC, oALUControl, oIllegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Instruction class from the ISA legality rules.
    function automatic int classify(input logic [31:0] ins, input bit m_en);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) return K_R;
                if (f7 == 7'h01 && m_en) return K_MD;
                return K_ILL;
            end
            7'h13: begin
                if (f3 == 3'd1 && f7 != 7'h00) return K_ILL;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return K_ILL;
                return K_I;
            end
            7'h37, 7'h17: return K_I;
            7'h03: return (f3 == 3'd3 || f3 >= 3'd6) ? K_ILL : K_LD;
            7'h23: return (f3 <= 3'd2) ? K_ST : K_ILL;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
            7'h6F: return K_JAL;
            7'h67: return (f3 == 3'd0) ? K_JALR : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    // ALU operation the instruction's mnemonic calls for.
    function automatic logic [4:0] alu_of(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (ins[6:0] == 7'h33 && ins[31:25] == 7'h01) return MD_TAB[f3];
        if (f3 == 3'd5) return ins[30] ? OPSRA : OPSRL;
        if (ins[6:0] == 7'h33 && f3 == 3'd0 && ins[30]) return OPSUB;
        return BASE_TAB[f3];
    endfunction

    // Control word each state is documented to drive.
    function automatic logic [20:0] exp_outs(input int st, input bit rdy, input logic [31:0] ins);
        logic pc, pcc, pcb, ir, iou, mr, mw, rw, opc, ill;
        logic [1:0] a, b, m2r;
        logic [4:0] alu;
        {pc, pcc, pcb, ir, iou, mr, mw, rw, opc, ill} = '0;
        a = 2'b00; b = 2'b00; m2r = 2'b00; alu = OPNULL;
        case (st)
            ST_FETCH:   begin mr = 1; a = 2'b01; b = 2'b01; alu = OPADD; pc = rdy; pcb = rdy; ir = rdy; end
            ST_DECODE:  begin a = 2'b10; b = 2'b10; alu = OPADD; end
            ST_EXEC_R:  alu = alu_of(ins);
            ST_EXEC_I: begin
                b = 2'b10;
                if (ins[6:0] == 7'h37) alu = OPLUI;
                else if (ins[6:0] == 7'h17) begin a = 2'b10; alu = OPADD; end
                else alu = alu_of(ins);
            end
            ST_MD_WAIT: alu = alu_of(ins);
            ST_WB_ALU:  rw = 1;
            ST_ADDR:    begin b = 2'b10; alu = OPADD; end
            ST_MEM_LD:  begin mr = 1; iou = 1; end
            ST_WB_MEM:  begin rw = 1; m2r = 2'b10; end
            ST_MEM_ST:  begin mw = 1; iou = 1; end
            ST_BRANCH:  begin alu = OPSUB; pcc = 1; opc = 1; end
            ST_JAL:     begin rw = 1; m2r = 2'b01; pc = 1; opc = 1; end
            ST_JALR:    begin b = 2'b10; alu = OPADD; pc = 1; rw = 1; m2r = 2'b01; end
            ST_ERROR:   ill = 1;
            default: ;
        endcase
        return {pc, pcc, pcb, ir, iou, mr, mw, rw, a, b, m2r, opc, alu, ill};
    endfunction

    task automatic push_states(input int st, input int n);
        for (int i = 0; i < n; i++) begin
            q_st.push_back(st);
            q_rdy.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic push_wait(input int st, input int waits);
        for (int i = 0; i < waits; i++) begin
            q_st.push_back(st);
            q_rdy.push_back(1'b0);
        end
        q_st.push_back(st);
        q_rdy.push_back(1'b1);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRSTn = 1'b0;
        #1;
        check("rst_ctrl", 32'(act), 32'd0);
        check("rst_state", 32'(oState), 32'd0);
        @(negedge iCLK);
        iMemReady = 1'b0;
        iRSTn = 1'b1;
        #1;
        check("rel_state", 32'(oState), ST_FETCH);
        check("rel_ctrl", 32'(act), 32'(exp_outs(ST_FETCH, 1'b0, iInstr)));
    endtask

    // Build the expected trace for one instruction, then drive and compare cycle by cycle.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int err_cycles);
        int k;
        k = classify(ins, 1'b1);
        q_st.delete();
        q_rdy.delete();
        push_wait(ST_FETCH, fw);
        push_states(ST_DECODE, 1);
        case (k)
            K_R:    push_states(ST_EXEC_R, 1);
            K_I:    push_states(ST_EXEC_I, 1);
            K_MD:   push_states(ST_MD_WAIT, LAT);
            K_LD:   begin push_states(ST_ADDR, 1); push_wait(ST_MEM_LD, mw); push_states(ST_WB_MEM, 1); end
            K_ST:   begin push_states(ST_ADDR, 1); push_wait(ST_MEM_ST, mw); end
            K_BR:   push_states(ST_BRANCH, 1);
            K_JAL:  push_states(ST_JAL, 1);
            K_JALR: push_states(ST_JALR, 1);
            default: push_states(ST_ERROR, err_cycles);
        endcase
        if (k == K_R || k == K_I || k == K_MD) push_states(ST_WB_ALU, 1);
        foreach (q_st[i]) begin
            @(negedge iCLK);
            if (i == 0) iInstr = ins;
            iMemReady = q_rdy[i];
            #1;
            check($sformatf("state_%08h_%0d", ins, i), 32'(oState), 32'(q_st[i]));
            check($sformatf("ctrl_%08h_%0d", ins, i), 32'(act), 32'(exp_outs(q_st[i], q_rdy[i], ins)));
        end
        if (k == K_ILL) do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int r;
        ins = $urandom();
        r = $urandom_range(0, 9);
        if (r < 9) ins[6:0] = OPC_TAB[r];
        case ($urandom_range(0, 5))
            0, 1, 2: ins[31:25] = 7'h00;
            3:       ins[31:25] = 7'h20;
            4:       ins[31:25] = 7'h01;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        do_reset();
        run_instr(32'h002081B3, 0, 0, 0);   // add x3,x1,x2
        run_instr(32'h0000A183, 0, 2, 0);   // lw x3,0(x1), two wait cycles
        run_instr(32'h022081B3, 1, 0, 0);   // mul x3,x1,x2
        run_instr(32'h00208063, 0, 0, 0);   // beq x1,x2,0
        run_instr(32'h0020A023, 0, 3, 0);   // sw x2,0(x1), three wait cycles
        run_instr(32'h4020D1B3, 0, 0, 0);   // sra
        run_instr(32'h123450B7, 0, 0, 0);   // lui
        run_instr(32'h0000007F, 2, 0, 100); // illegal opcode, sticky ERROR then reset
        for (int n = 0; n < 150; n++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), 3);

        // M-extension disabled: mul must trap.
        instr_b = 32'h022081B3;
        rdy_b = 1'b1;
        do_reset();
        check("nom_fetch", 32'(state_b), ST_FETCH);
        @(negedge iCLK);
        #1;
        check("nom_decode", 32'(state_b), ST_DECODE);
        @(negedge iCLK);
        #1;
        check("nom_error", 32'(state_b), ST_ERROR);
        check("nom_illegal", 32'(ill_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_multi.md
# control_multi

Multicycle control unit for the RV32I/RV32M core: a Moore state machine that sequences each instruction over 3–5+ cycles, sharing a single ALU and a single memory port. It replaces the single-cycle decoder in the multicycle datapath, driving PC/IR/register-file/memory enables and mux selects from the latched instruction register. It adds a memory-ready handshake, a parametrised multi-cycle MUL/DIV wait, and a sticky illegal-instruction state.

## Interface
- RV32M, 1: 1 enables M-extension decode; 0 makes funct7=0000001 on OPC_RTYPE illegal.
- MULDIV_LAT, 8: ALU cycles a MUL/DIV/REM needs; legal range 1..63.

- iCLK  in  1  core clock, all state changes on rising edge.
- iRSTn  in  1  reset, asynchronous, active-low.
- iInstr  in  32  instruction register contents (valid from DECODE onward).
- iMemReady  in  1  memory port completes the current read/write this cycle.
- oEscrevePC, oEscrevePCCond, oEscrevePCBack, oEscreveIR  out  1 each  PC write, conditional PC write (branch unit decides using funct3), PC-back latch, IR latch.
- oIouD  out  1  memory address: 0 PC, 1 ALUOut.
- oMemRead, oMemWrite, oRegWrite  out  1 each.
- oOrigAULA  out  2  00 rs1, 01 PC, 10 PCBack.
- oOrigBULA  out  2  00 rs2, 01 constant 4, 10 immediate.
- oMem2Reg  out  2  00 ALUOut, 01 PC (holds PC+4), 10 MDR.
- oOrigPC  out  1  0 ALU result, 1 ALUOut.
- oALUControl  out  5  OP* codes from Parametros.v.
- oState  out  4  current state, for debug.
- oIllegal  out  1  high while in ERROR.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_LD, MEM_ST, WB_ALU, WB_MEM, BRANCH, JAL, JALR, MD_WAIT, ERROR.
- FETCH: oMemRead=1, oIouD=0, oOrigAULA=01, oOrigBULA=01, OPADD. oEscreveIR, oEscrevePC, oEscrevePCBack asserted only in the cycle iMemReady=1; stay in FETCH otherwise → DECODE.
- DECODE: ALUOut ← PCBack+imm (oOrigAULA=10, oOrigBULA=10, OPADD). Next: OPC_RTYPE→EXEC_R (or MD_WAIT if funct7=MULDIV and RV32M); OPC_OPIMM/OPC_LUI/OPC_AUIPC→EXEC_I; OPC_LOAD/OPC_STORE→ADDR; OPC_BRANCH→BRANCH; OPC_JAL→JAL; OPC_JALR→JALR; anything else, or an invalid funct3/funct7 combination under the single-cycle decoding rules→ERROR.
- EXEC_R: rs1 op rs2, ALU code decoded from funct3/funct7 → WB_ALU.
- EXEC_I: OPIMM uses rs1/imm with funct3 decode (SRAI via funct7). LUI uses OPLUI with B=imm. AUIPC uses A=PCBack, B=imm, OPADD → WB_ALU.
- MD_WAIT: operands rs1/rs2 with OPMUL..OPREMU held constant; 6-bit counter loaded with MULDIV_LAT-1 on entry and decremented each cycle; leave to WB_ALU in the cycle the counter reads 0.
- WB_ALU: oRegWrite=1, oMem2Reg=00 → FETCH.
- ADDR: rs1+imm, OPADD → MEM_LD (load) or MEM_ST (store).
- MEM_LD: oMemRead=1, oIouD=1; wait for iMemReady → WB_MEM. WB_MEM: oRegWrite=1, oMem2Reg=10 → FETCH.
- MEM_ST: oMemWrite=1, oIouD=1, held until iMemReady → FETCH.
- BRANCH: rs1 vs rs2, OPSUB, oEscrevePCCond=1, oOrigPC=1 → FETCH.
- JAL: oRegWrite=1, oMem2Reg=01, oEscrevePC=1, oOrigPC=1 → FETCH.
- JALR: rs1+imm (oOrigBULA=10), oEscrevePC=1, oOrigPC=0, oRegWrite=1, oMem2Reg=01 → FETCH.
- ERROR: all enables 0, oIllegal=1, sticky until reset.
- Any control not listed for a state is 0. oALUControl=OPNULL where no ALU use is specified.

## Timing
- State register and counter reset asynchronously to FETCH/0 when iRSTn falls. While iRSTn=0, every output is forced to 0 combinationally, including oState=0.
- Outputs are a combinational function of the state (and iInstr). FETCH write enables also depend on iMemReady (Mealy gating).
- Cycles with zero-wait memory: branch/JAL/JALR 3; R-type/OPIMM/LUI/AUIPC/store 4; load 5; M-ops 3+MULDIV_LAT. Each wait cycle on iMemReady adds one.
- Reset mid-instruction abandons it. The first cycle after release is FETCH.
- rd write and PC write in the same JAL/JALR cycle are legal: the register file samples the old PC (PC+4).

## Test plan
- add x3,x1,x2 (0x002081B3), iMemReady=1 always → states FETCH,DECODE,EXEC_R,WB_ALU; oALUControl=OPADD in EXEC_R; oRegWrite=1 only in cycle 4.
- lw with iMemReady low 2 cycles in MEM_LD → 7 cycles total; oMemRead and oIouD=1 held throughout MEM_LD; oRegWrite with oMem2Reg=10 once.
- mul (funct7 0000001), RV32M=1, MULDIV_LAT=8 → exactly 8 cycles in MD_WAIT with OPMUL, then WB_ALU. With RV32M=0 the same instruction → ERROR, oIllegal=1.
- beq → BRANCH in cycle 3 with oEscrevePCCond=1, oOrigPC=1, OPSUB; next cycle FETCH.
- Opcode 0x7F → ERROR, held for 100 cycles. Assert iRSTn low mid-ERROR → all outputs 0 immediately; after release oState=FETCH.
- sw with iMemReady low 3 cycles → oMemWrite stays high 4 cycles, then FETCH; oRegWrite never asserted.
